// File: rtl/ibex_pext_mac_seq.sv
// Multi-cycle sequencer for the 32-bit multiply-accumulate ops: four 16x16 partial
// products on a shared 17x17 multiplier, then one borrowed ALU-adder cycle to combine with rd.
module ibex_pext_mac_seq (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        kill_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [31:0] op_c_i,
    output logic [16:0] mul_op_a_o,
    output logic [16:0] mul_op_b_o,
    input  logic [33:0] mul_result_i,
    output logic        alu_req_o,
    input  logic        alu_gnt_i,
    output logic [31:0] alu_op_a_o,
    output logic [31:0] alu_op_b_o,
    output logic [1:0]  alu_sub_o,
    input  logic [31:0] alu_result_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        ov_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ALBL, S_ALBH, S_AHBL, S_AHBH, S_ACCUM, S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic        ov_q, ov_d;

    logic        is_low, is_sub, is_rnd, op_reserved_in;
    logic [63:0] pp_ext;
    logic [31:0] word;
    logic        sat_ovf;
    logic [31:0] sat_val;

    assign is_low         = (op_q[2:1] == 2'b00);
    assign is_sub         = op_q[0];
    assign is_rnd         = op_q[2];
    assign op_reserved_in = op_i[2] & op_i[1];
    assign pp_ext         = {{30{mul_result_i[33]}}, mul_result_i};

    // Rounding adds 2^31 before taking the high word: equivalent to adding bit 31 to it.
    always_comb begin
        if (is_low) begin
            word = acc_q[31:0];
        end else if (is_rnd) begin
            word = acc_q[63:32] + {31'b0, acc_q[31]};
        end else begin
            word = acc_q[63:32];
        end
    end

    assign sat_ovf = !is_low
                   && (is_sub ? (op_c_q[31] != word[31]) : (op_c_q[31] == word[31]))
                   && (alu_result_i[31] != op_c_q[31]);
    assign sat_val = op_c_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i && !kill_i) state_d = op_reserved_in ? S_DONE : S_ALBL;
            S_ALBL:  state_d = S_ALBH;
            S_ALBH:  state_d = S_AHBL;
            S_AHBL:  state_d = is_low ? S_ACCUM : S_AHBH;
            S_AHBH:  state_d = S_ACCUM;
            S_ACCUM: if (alu_gnt_i) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (kill_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    // Outputs
    always_comb begin
        mul_op_a_o = '0;
        mul_op_b_o = '0;
        case (state_q)
            S_ALBL: begin
                mul_op_a_o = {1'b0, op_a_q[15:0]};
                mul_op_b_o = {1'b0, op_b_q[15:0]};
            end
            S_ALBH: begin
                mul_op_a_o = {1'b0, op_a_q[15:0]};
                mul_op_b_o = {op_b_q[31], op_b_q[31:16]};
            end
            S_AHBL: begin
                mul_op_a_o = {op_a_q[31], op_a_q[31:16]};
                mul_op_b_o = {1'b0, op_b_q[15:0]};
            end
            S_AHBH: begin
                mul_op_a_o = {op_a_q[31], op_a_q[31:16]};
                mul_op_b_o = {op_b_q[31], op_b_q[31:16]};
            end
            default: ;
        endcase
        alu_req_o  = (state_q == S_ACCUM);
        alu_op_a_o = alu_req_o ? op_c_q : '0;
        alu_op_b_o = alu_req_o ? word : '0;
        alu_sub_o  = (alu_req_o && is_sub) ? 2'b11 : 2'b00;
        ready_o    = (state_q == S_IDLE);
        valid_o    = (state_q == S_DONE) && !kill_i;
    end

    assign result_o = result_q;
    assign ov_o     = ov_q;

    // Datapath next-state
    always_comb begin
        op_d     = op_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_c_d   = op_c_q;
        acc_d    = acc_q;
        result_d = result_q;
        ov_d     = ov_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !kill_i) begin
                    op_d   = op_i;
                    op_a_d = op_a_i;
                    op_b_d = op_b_i;
                    op_c_d = op_c_i;
                    acc_d  = '0;
                    if (op_reserved_in) begin
                        result_d = op_c_i;
                        ov_d     = 1'b0;
                    end
                end
            end
            S_ALBL:         acc_d = acc_q + pp_ext;
            S_ALBH, S_AHBL: acc_d = acc_q + (pp_ext << 16);
            S_AHBH:         acc_d = acc_q + (pp_ext << 32);
            S_ACCUM: begin
                if (alu_gnt_i && !kill_i) begin
                    result_d = sat_ovf ? sat_val : alu_result_i;
                    ov_d     = sat_ovf;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_c_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ov_q     <= 1'b0;
        end else begin
            op_q     <= op_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_c_q   <= op_c_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ov_q     <= ov_d;
        end
    end

endmodule

// File: doc/ibex_pext_mac_seq.md
# ibex_pext_mac_seq

Multi-cycle sequencer for the Zpn 32-bit multiply-accumulate instructions MADDR32, MSUBR32, KMMAC, KMMAC.u, KMMSB and KMMSB.u. It splits the 32x32 product into four 16x16 partial products on a shared 17x17 signed multiplier and accumulates them in a 64-bit register. It then borrows the ALU adder for one cycle to add or subtract the selected product word to or from rd, applying saturation where the op requires it. It sits beside the ALU in the EX stage and sequences the ALU adder through a request/grant pair.

## Interface
Parameters:
- none

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  operands and op are valid; accepted only when ready_o=1
- kill_i  in  1  abort the current op
- op_i  in  3  0 MADDR32, 1 MSUBR32, 2 KMMAC, 3 KMMSB, 4 KMMAC.u, 5 KMMSB.u; codes 6 and 7 are reserved
- op_a_i  in  32  rs1
- op_b_i  in  32  rs2
- op_c_i  in  32  rd (accumulator source)
- mul_op_a_o  out  17  signed multiplier operand A
- mul_op_b_o  out  17  signed multiplier operand B
- mul_result_i  in  34  signed product from the shared multiplier, combinational, same cycle
- alu_req_o  out  1  request for the ALU adder
- alu_gnt_i  in  1  ALU adder granted this cycle
- alu_op_a_o  out  32  adder operand A (latched rd)
- alu_op_b_o  out  32  adder operand B (selected product word)
- alu_sub_o  out  2  2'b11 selects subtract, 2'b00 selects add (same encoding the ALU subtraction decoder uses)
- alu_result_i  in  32  adder sum, combinational
- ready_o  out  1  block is idle and can accept start_i
- valid_o  out  1  one-cycle result strobe
- result_o  out  32  result, held until the next accepted start
- ov_o  out  1  saturation occurred; valid alongside result_o

## Operation
- States: IDLE, ALBL, ALBH, AHBL, AHBH, ACCUM, DONE.
- IDLE, start_i=1, kill_i=0:
  - Latch op_a_i, op_b_i, op_c_i and op_i.
  - Clear the 64-bit accumulator.
  - Go to ALBL.
- Partial products:
  - Low halves are zero-extended to 17 bits.
  - High halves are sign-extended to 17 bits.
  - ALBL: acc += AL*BL.
  - ALBH: acc += (AL*BH)<<16.
  - AHBL: acc += (AH*BL)<<16.
  - AHBH: acc += (AH*BH)<<32.
  - Every addition sign-extends to 64 bits.
- MADDR32 and MSUBR32 skip AHBH and go AHBL to ACCUM. Only acc[31:0] is used.
- Product word driven on alu_op_b_o:
  - MADDR32, MSUBR32: acc[31:0].
  - KMMAC, KMMSB: acc[63:32].
  - .u variants: (acc + 2^31)[63:32]. This cannot overflow the 64-bit accumulator.
- ACCUM:
  - alu_req_o=1, alu_op_a_o=rd.
  - alu_sub_o=2'b11 for MSUBR32, KMMSB and KMMSB.u; 2'b00 otherwise.
  - The FSM stays in ACCUM, with every output stable, until alu_gnt_i=1.
  - On the grant cycle, result_o and ov_o are registered and the FSM goes to DONE.
- Saturation, K ops only. Let a=rd, b=word, r=sum.
  - Add overflows when a[31]==b[31] and r[31]!=a[31].
  - Subtract overflows when a[31]!=b[31] and r[31]!=a[31].
  - On overflow: result = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF, ov_o=1.
  - MADDR32 and MSUBR32 wrap, ov_o=0.
- DONE: valid_o=1 for one cycle, then the FSM returns to IDLE.
- Reserved op codes 6 and 7: IDLE goes directly to DONE. result_o = rd unchanged, ov_o=0. The multiplier and ALU are not requested.
- kill_i in any non-IDLE state: the next state is IDLE, valid_o is not asserted, and result_o and ov_o keep their previous values.
- kill_i together with start_i in IDLE: kill wins and the start is dropped.
- start_i while busy is ignored; the bench must not drive it.

## Timing
- Reset values:
  - FSM in IDLE, ready_o=1.
  - valid_o=0, alu_req_o=0, alu_sub_o=2'b00.
  - result_o=0, ov_o=0.
  - mul_op_a_o=0, mul_op_b_o=0, alu_op_a_o=0, alu_op_b_o=0.
  - Accumulator cleared.
- Reset mid-operation returns to IDLE immediately (asynchronous). No valid_o is produced.
- Start accepted at clock edge 0, with alu_gnt_i held high:
  - Low-word ops: ALBL in cycle 1, ACCUM in cycle 4, valid_o in cycle 5.
  - High-word ops: ACCUM in cycle 5, valid_o in cycle 6.
- Each grant-low cycle in ACCUM adds one cycle of latency.
- ready_o=1 only in IDLE. It rises in the cycle after DONE or after a kill.
- Multiplier operands are driven only in ALBL to AHBH; they are 0 otherwise.

## Test plan
- MADDR32, a=3, b=5, c=10, grant high -> result_o=25, ov_o=0, valid_o in cycle 5, single pulse.
- KMMAC, a=b=0x4000_0000, c=0x7000_0000 -> hi=0x1000_0000, sum overflows -> result_o=0x7FFF_FFFF, ov_o=1, valid_o in cycle 6.
- KMMSB.u, a=0xFFFF_FFFF, b=0x8000_0000, c=0 -> rounded hi=1, result_o=0xFFFF_FFFF, ov_o=0. The same operands with KMMSB give result_o=0.
- MSUBR32, a=b=0x0001_0000, c=7 -> result_o=7. Then a=2, b=3, c=0 -> result_o=0xFFFF_FFFA.
- KMMAC with alu_gnt_i low for 3 cycles in ACCUM -> alu_req_o, alu_op_a_o, alu_op_b_o and alu_sub_o stable throughout; valid_o in cycle 9.
- kill_i in ALBH -> no valid_o, ready_o=1 next cycle, result_o unchanged. rst_ni asserted in AHBL -> all outputs at reset values immediately. kill_i together with start_i in IDLE -> start dropped.
